// File: rtl/pio_ram_responder.sv
// Far end of the 2-pin PIO RAM link: decodes request frames, serves them from a word RAM,
// and returns read data as response frames. Define PIO_RAM_RESP_STATS_EN to enable rd/wr counters.
//   state       | meaning
//   RX_IDLE     | waiting for an opcode symbol
//   RX_ADDR_RD  | shifting in the address of a read
//   RX_ADDR_WR  | shifting in the address of a write
//   RX_DATA_WR  | shifting in write data; RAM written on the last symbol
//   TX_IDLE     | driving 00
//   TX_START    | driving the 01 start symbol
//   TX_DATA     | driving data symbols, MSB pair first
module pio_ram_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_pins,
  output logic [1:0]  resp_pins,
  output logic        busy,
  output logic        proto_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);
  localparam int ADDR_SYM = ADDR_BITS / 2;
  localparam int DATA_SYM = DATA_BITS / 2;
  localparam int MAX_SYM  = (ADDR_SYM > DATA_SYM) ? ADDR_SYM : DATA_SYM;
  localparam int CNT_W    = $clog2(MAX_SYM) + 1;
  localparam int LAT_W    = $clog2(READ_LATENCY) + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_ADDR_RD, RX_ADDR_WR, RX_DATA_WR} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA} tx_state_t;

  rx_state_t            rx_state;
  tx_state_t            tx_state;
  logic [1:0]           req_q;
  logic [CNT_W-1:0]     rx_cnt;
  logic [CNT_W-1:0]     tx_cnt;
  logic [ADDR_BITS-1:0] addr_sh;
  logic [DATA_BITS-1:0] data_sh;
  logic [ADDR_BITS-1:0] addr_nx;
  logic [DATA_BITS-1:0] data_nx;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [DATA_BITS-1:0] slot_data;
  logic [DATA_BITS-1:0] tx_sh;
  logic [LAT_W-1:0]     pend_cnt;
  logic                 pend_valid;
  logic                 fetch;
  logic                 rd_issue;
  logic                 rd_drop;
  logic                 wr_en;
  logic                 tx_start;
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  assign addr_nx  = {addr_sh[ADDR_BITS-3:0], req_q};
  assign data_nx  = {data_sh[DATA_BITS-3:0], req_q};
  assign rd_issue = (rx_state == RX_ADDR_RD) && (rx_cnt == '0);
  assign wr_en    = (rx_state == RX_DATA_WR) && (rx_cnt == '0);
  assign rd_drop  = rd_issue && pend_valid && (tx_state != TX_IDLE);
  // A new frame may start straight after the last data symbol, so no idle gap is inserted.
  assign tx_start = pend_valid && (pend_cnt == '0) &&
                    ((tx_state == TX_IDLE) || ((tx_state == TX_DATA) && (tx_cnt == '0)));
  assign busy     = (rx_state != RX_IDLE) || (tx_state != TX_IDLE) || pend_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= 2'b00;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      addr_sh  <= '0;
      data_sh  <= '0;
    end else begin
      req_q <= req_pins;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= CNT_W'(ADDR_SYM - 1);
          if (req_q == 2'b01)      rx_state <= RX_ADDR_RD;
          else if (req_q == 2'b10) rx_state <= RX_ADDR_WR;
        end
        RX_ADDR_RD: begin
          addr_sh <= addr_nx;
          if (rx_cnt == '0) rx_state <= RX_IDLE;
          else              rx_cnt   <= rx_cnt - CNT_W'(1);
        end
        RX_ADDR_WR: begin
          addr_sh <= addr_nx;
          if (rx_cnt == '0) begin
            rx_state <= RX_DATA_WR;
            rx_cnt   <= CNT_W'(DATA_SYM - 1);
          end else begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end
        end
        default: begin
          data_sh <= data_nx;
          if (rx_cnt == '0) rx_state <= RX_IDLE;
          else              rx_cnt   <= rx_cnt - CNT_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) proto_err <= 1'b0;
    else if (((rx_state == RX_IDLE) && (req_q == 2'b11)) || rd_drop) proto_err <= 1'b1;
  end

  // Pending slot: accepted read waits READ_LATENCY-1 edges before it may start a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_cnt   <= '0;
      rd_addr    <= '0;
      fetch      <= 1'b0;
    end else if (rd_issue && !rd_drop) begin
      pend_valid <= 1'b1;
      pend_cnt   <= LAT_W'(READ_LATENCY - 1);
      rd_addr    <= addr_nx;
      fetch      <= 1'b1;
    end else begin
      fetch <= 1'b0;
      if (tx_start)          pend_valid <= 1'b0;
      if (pend_cnt != '0)    pend_cnt   <= pend_cnt - LAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_sh] <= data_nx;
    if (fetch) slot_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_sh     <= '0;
      resp_pins <= 2'b00;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_start) begin
            tx_state  <= TX_START;
            resp_pins <= 2'b01;
          end else begin
            resp_pins <= 2'b00;
          end
        end
        TX_START: begin
          tx_state  <= TX_DATA;
          resp_pins <= slot_data[DATA_BITS-1 -: 2];
          tx_sh     <= {slot_data[DATA_BITS-3:0], 2'b00};
          tx_cnt    <= CNT_W'(DATA_SYM - 1);
        end
        default: begin
          if (tx_cnt != '0) begin
            resp_pins <= tx_sh[DATA_BITS-1 -: 2];
            tx_sh     <= {tx_sh[DATA_BITS-3:0], 2'b00};
            tx_cnt    <= tx_cnt - CNT_W'(1);
          end else if (tx_start) begin
            tx_state  <= TX_START;
            resp_pins <= 2'b01;
          end else begin
            tx_state  <= TX_IDLE;
            resp_pins <= 2'b00;
          end
        end
      endcase
    end
  end

`ifdef PIO_RAM_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      if (tx_start) rd_count <= rd_count + 16'd1;
      if (wr_en)    wr_count <= wr_count + 16'd1;
    end
  end
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_pio_ram_responder.sv
// Scoreboard bench for pio_ram_responder: stimulus queues expected response frames,
// a monitor decodes resp_pins and checks start cycle and data word of each frame.
module tb_pio_ram_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_pins = 2'b00;
  logic [1:0]  resp_pins;
  logic        busy;
  logic        proto_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

`ifdef PIO_RAM_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  pio_ram_responder #(.ADDR_BITS(8), .DATA_BITS(16), .READ_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_pins(req_pins), .resp_pins(resp_pins),
    .busy(busy), .proto_err(proto_err), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] word;
    int          start;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          last_start = -100;
  bit          mon_active = 1'b0;
  int          mon_n = 0;
  logic [15:0] mon_word;
  exp_t        cur;
  bit          cur_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_cnt(input int r, input int w);
    chk("rd_count", {16'd0, rd_count}, STATS ? r : 0);
    chk("wr_count", {16'd0, wr_count}, STATS ? w : 0);
  endtask

  // Monitor: a frame is 01 followed by eight data symbols.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      cur_valid  = 1'b0;
      sb.delete();
    end else if (!mon_active) begin
      if (resp_pins == 2'b01) begin
        mon_active = 1'b1;
        mon_n      = 0;
        mon_word   = 16'h0;
        if (sb.size() == 0) begin
          cur_valid = 1'b0;
          failures++;
          $display("FAIL unexpected_frame: start symbol at cycle %0d, none expected", cyc);
        end else begin
          cur       = sb.pop_front();
          cur_valid = 1'b1;
          chk("start_cycle", cyc, cur.start);
        end
      end else if (resp_pins != 2'b00) begin
        failures++;
        $display("FAIL idle_symbol: got %b expected 00 (cycle %0d)", resp_pins, cyc);
      end
    end else begin
      mon_word = {mon_word[13:0], resp_pins};
      mon_n++;
      if (mon_n == 8) begin
        mon_active = 1'b0;
        if (cur_valid) chk("resp_word", mon_word, cur.word);
      end
    end
  end

  task automatic send_sym(input logic [1:0] sym);
    @(negedge clk);
    req_pins = sym;
  endtask

  task automatic send_frame(input logic [1:0] op, input logic [7:0] a, input logic [15:0] d,
                            output int s);
    send_sym(op);
    for (int i = 3; i >= 0; i--) send_sym(a[2*i+1 -: 2]);
    s = cyc + 1;
    if (op == 2'b10)
      for (int i = 7; i >= 0; i--) send_sym(d[2*i+1 -: 2]);
  endtask

  task automatic write_word(input logic [7:0] a, input logic [15:0] d);
    int s;
    send_frame(2'b10, a, d, s);
  endtask

  task automatic read_exp(input logic [7:0] a, input logic [15:0] w, output int s);
    int e;
    send_frame(2'b01, a, 16'h0, s);
    e = (s + 3 > last_start + 9) ? s + 3 : last_start + 9;
    last_start = e;
    sb.push_back('{word: w, start: e});
  endtask

  task automatic idle(input int n);
    repeat (n) send_sym(2'b00);
  endtask

  task automatic wait_quiet();
    int k = 0;
    while (k < 300 && !(busy == 1'b0 && sb.size() == 0 && !mon_active)) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", k < 300, 1);
  endtask

  initial begin
    int s, sa, sb2, sc;
    repeat (3) @(negedge clk);
    chk("rst_resp", resp_pins, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_proto_err", proto_err, 0);
    chk_cnt(0, 0);
    rst_n = 1'b1;
    idle(2);

    // Write 0x1BEB to 0x12, no response expected.
    write_word(8'h12, 16'h1BEB);
    idle(6);
    chk("wr_busy_low", busy, 0);
    chk_cnt(0, 1);

    // Single read, start two edges after the last address symbol is taken.
    read_exp(8'h12, 16'h1BEB, s);
    idle(1);
    wait_quiet();
    chk_cnt(1, 1);

    // Write followed at once by reads, the second read hits the fresh write.
    write_word(8'h34, 16'hA5C3);
    read_exp(8'h12, 16'h1BEB, s);
    read_exp(8'h34, 16'hA5C3, s);
    idle(1);
    wait_quiet();
    chk_cnt(3, 2);

    // Reserved opcode.
    chk("proto_err_before", proto_err, 0);
    send_sym(2'b11);
    idle(4);
    chk("proto_err_reserved", proto_err, 1);
    chk_cnt(3, 2);
    read_exp(8'h34, 16'hA5C3, s);
    idle(1);
    wait_quiet();
    chk_cnt(4, 2);

    // Reset pulse clears sticky error and counters, RAM kept.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("pulse_proto_err", proto_err, 0);
    chk_cnt(0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_start = -100;
    idle(2);

    // Three back-to-back reads: third is dropped.
    read_exp(8'h12, 16'h1BEB, sa);
    read_exp(8'h34, 16'hA5C3, sb2);
    send_frame(2'b01, 8'h12, 16'h0, sc);
    idle(1);
    while (cyc < sa + 20) @(negedge clk);
    chk("busy_last_sym", busy, 1);
    @(negedge clk);
    chk("busy_after_frame2", busy, 0);
    chk("proto_err_drop", proto_err, 1);
    wait_quiet();
    chk_cnt(2, 0);

    // Reset in the middle of a response frame.
    read_exp(8'h12, 16'h1BEB, s);
    idle(1);
    while (cyc < s + 7) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_resp", resp_pins, 2'b00);
    chk("midrst_busy", busy, 0);
    chk("midrst_proto_err", proto_err, 0);
    chk_cnt(0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_start = -100;
    idle(2);
    read_exp(8'h34, 16'hA5C3, s);
    idle(1);
    wait_quiet();
    chk_cnt(1, 0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
